// File: rtl/bira_greedy_alloc.sv
// rtl/bira_greedy_alloc.sv - fault CAM collection, pivot early-termination and greedy spare allocation
module bira_greedy_alloc #(
    parameter int ROW_W  = 10,
    parameter int COL_W  = 10,
    parameter int BANK_W = 2,
    parameter int NUM_SR = 2,
    parameter int NUM_SC = 2,
    parameter int FCAM_D = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     fault_detect,
    input  logic [BANK_W-1:0]                        bank_in,
    input  logic [ROW_W-1:0]                         row_add_in,
    input  logic [COL_W-1:0]                         col_add_in,
    input  logic                                     test_end,
    output logic                                     early_term,
    output logic                                     done,
    output logic                                     repair,
    output logic                                     sol_valid,
    input  logic                                     sol_ready,
    output logic                                     sol_is_col,
    output logic [BANK_W-1:0]                        sol_bank,
    output logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] sol_addr
);
    localparam int AW     = (ROW_W > COL_W) ? ROW_W : COL_W;
    localparam int IDX_W  = $clog2(FCAM_D);
    localparam int CNT_W  = $clog2(FCAM_D + 1);
    localparam int SOL_D  = NUM_SR + NUM_SC;
    localparam int SOL_W  = $clog2(SOL_D + 1);
    localparam int SOL_IW = $clog2(SOL_D);
    localparam int RL_W   = $clog2(NUM_SR + 1);
    localparam int CL_W   = $clog2(NUM_SC + 1);

    typedef enum logic [2:0] {S_COLLECT, S_FIND, S_COUNT, S_MARK, S_EMIT, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic              r_vld  [FCAM_D];
    logic              r_piv  [FCAM_D];
    logic              r_cov  [FCAM_D];
    logic [BANK_W-1:0] r_bank [FCAM_D];
    logic [ROW_W-1:0]  r_row  [FCAM_D];
    logic [COL_W-1:0]  r_col  [FCAM_D];
    logic [CNT_W-1:0]  r_cnt, r_piv_cnt, r_rc, r_cc;
    logic [IDX_W-1:0]  r_idx;
    logic [BANK_W-1:0] r_p_bank;
    logic [ROW_W-1:0]  r_p_row;
    logic [COL_W-1:0]  r_p_col;
    logic              r_sel_col, r_rep_ok, r_early, r_done, r_repair;
    logic [RL_W-1:0]   r_rows_left;
    logic [CL_W-1:0]   r_cols_left;
    logic              r_sol_col  [SOL_D];
    logic [BANK_W-1:0] r_sol_bank [SOL_D];
    logic [AW-1:0]     r_sol_addr [SOL_D];
    logic [SOL_W-1:0]  r_sol_cnt, r_emit_idx;

    logic              w_dup, w_conf, w_new, w_full, w_piv, w_et;
    logic              w_uncov, w_row_hit, w_col_hit, w_last, w_no_spares, w_pick_col, w_mark_hit;
    logic [CNT_W-1:0]  w_rc_n, w_cc_n;
    logic [SOL_IW-1:0] w_sol_wi, w_sol_ri;

    // Associative search of the incoming fault against stored entries and stored pivots
    always_comb begin
        w_dup  = 1'b0;
        w_conf = 1'b0;
        for (int i = 0; i < FCAM_D; i++) begin
            if (r_vld[i] && r_bank[i] == bank_in && r_row[i] == row_add_in && r_col[i] == col_add_in)
                w_dup = 1'b1;
            if (r_vld[i] && r_piv[i] && r_bank[i] == bank_in &&
                (r_row[i] == row_add_in || r_col[i] == col_add_in))
                w_conf = 1'b1;
        end
    end

    assign w_new  = fault_detect && !w_dup;
    assign w_full = (r_cnt == CNT_W'(FCAM_D));
    assign w_piv  = w_new && !w_full && !w_conf;
    // CAM overflow or one pivot more than the spare pool can ever cover
    assign w_et   = w_new && (w_full || (w_piv && r_piv_cnt == CNT_W'(SOL_D)));

    assign w_uncov     = r_vld[r_idx] && !r_cov[r_idx];
    assign w_row_hit   = w_uncov && r_bank[r_idx] == r_p_bank && r_row[r_idx] == r_p_row;
    assign w_col_hit   = w_uncov && r_bank[r_idx] == r_p_bank && r_col[r_idx] == r_p_col;
    assign w_last      = (r_idx == IDX_W'(FCAM_D - 1));
    assign w_no_spares = (r_rows_left == '0) && (r_cols_left == '0);
    assign w_rc_n      = r_rc + CNT_W'(w_row_hit);
    assign w_cc_n      = r_cc + CNT_W'(w_col_hit);
    // Row wins ties; fall back to whichever pool still has spares
    assign w_pick_col  = !(((w_rc_n >= w_cc_n) && (r_rows_left != '0)) || (r_cols_left == '0));
    assign w_mark_hit  = r_sel_col ? w_col_hit : w_row_hit;
    assign w_sol_wi    = r_sol_cnt[SOL_IW-1:0];
    assign w_sol_ri    = r_emit_idx[SOL_IW-1:0];

    assign early_term = r_early;
    assign done       = r_done;
    assign repair     = r_repair;
    assign sol_valid  = (r_state == S_EMIT) && (r_emit_idx != r_sol_cnt);
    assign sol_is_col = sol_valid & r_sol_col[w_sol_ri];
    assign sol_bank   = sol_valid ? r_sol_bank[w_sol_ri] : '0;
    assign sol_addr   = sol_valid ? r_sol_addr[w_sol_ri] : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_COLLECT;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic for collection, the three scan phases and emission
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_et) w_state_nxt = S_DONE;
                       else if (test_end) w_state_nxt = S_FIND;
            S_FIND:    if (w_uncov) w_state_nxt = w_no_spares ? S_EMIT : S_COUNT;
                       else if (w_last) w_state_nxt = S_EMIT;
            S_COUNT:   if (w_last) w_state_nxt = S_MARK;
            S_MARK:    if (w_last) w_state_nxt = S_FIND;
            S_EMIT:    if (r_emit_idx == r_sol_cnt) w_state_nxt = S_DONE;
            default:   w_state_nxt = S_DONE;
        endcase
    end

    // CAM, allocation bookkeeping, solution list and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FCAM_D; i++) begin
                r_vld[i]  <= 1'b0;
                r_piv[i]  <= 1'b0;
                r_cov[i]  <= 1'b0;
                r_bank[i] <= '0;
                r_row[i]  <= '0;
                r_col[i]  <= '0;
            end
            for (int j = 0; j < SOL_D; j++) begin
                r_sol_col[j]  <= 1'b0;
                r_sol_bank[j] <= '0;
                r_sol_addr[j] <= '0;
            end
            r_cnt       <= '0;
            r_piv_cnt   <= '0;
            r_rc        <= '0;
            r_cc        <= '0;
            r_idx       <= '0;
            r_p_bank    <= '0;
            r_p_row     <= '0;
            r_p_col     <= '0;
            r_sel_col   <= 1'b0;
            r_rep_ok    <= 1'b0;
            r_early     <= 1'b0;
            r_done      <= 1'b0;
            r_repair    <= 1'b0;
            r_rows_left <= RL_W'(NUM_SR);
            r_cols_left <= CL_W'(NUM_SC);
            r_sol_cnt   <= '0;
            r_emit_idx  <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    r_idx <= '0;
                    if (w_new && !w_full) begin
                        r_vld[r_cnt[IDX_W-1:0]]  <= 1'b1;
                        r_piv[r_cnt[IDX_W-1:0]]  <= w_piv;
                        r_bank[r_cnt[IDX_W-1:0]] <= bank_in;
                        r_row[r_cnt[IDX_W-1:0]]  <= row_add_in;
                        r_col[r_cnt[IDX_W-1:0]]  <= col_add_in;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_piv) r_piv_cnt <= r_piv_cnt + 1'b1;
                    end
                    if (w_et) begin
                        r_early <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                S_FIND: begin
                    if (w_uncov) begin
                        r_p_bank <= r_bank[r_idx];
                        r_p_row  <= r_row[r_idx];
                        r_p_col  <= r_col[r_idx];
                        r_idx    <= '0;
                        r_rc     <= '0;
                        r_cc     <= '0;
                        r_rep_ok <= 1'b0;
                    end else if (w_last) begin
                        r_rep_ok <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_COUNT: begin
                    r_rc <= w_rc_n;
                    r_cc <= w_cc_n;
                    if (w_last) begin
                        r_idx     <= '0;
                        r_sel_col <= w_pick_col;
                        if (w_pick_col) r_cols_left <= r_cols_left - 1'b1;
                        else            r_rows_left <= r_rows_left - 1'b1;
                        r_sol_col[w_sol_wi]  <= w_pick_col;
                        r_sol_bank[w_sol_wi] <= r_p_bank;
                        r_sol_addr[w_sol_wi] <= w_pick_col ? AW'(r_p_col) : AW'(r_p_row);
                        r_sol_cnt <= r_sol_cnt + 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_MARK: begin
                    if (w_mark_hit) r_cov[r_idx] <= 1'b1;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                S_EMIT: begin
                    if (sol_valid && sol_ready) r_emit_idx <= r_emit_idx + 1'b1;
                    if (r_emit_idx == r_sol_cnt) begin
                        r_done   <= 1'b1;
                        r_repair <= r_rep_ok;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bira_greedy_alloc.sv
// tb/tb_bira_greedy_alloc.sv - scoreboard bench for bira_greedy_alloc
module tb_bira_greedy_alloc;
    logic       clk = 1'b0;
    logic       rst;
    logic       fault_detect;
    logic [1:0] bank_in;
    logic [9:0] row_add_in;
    logic [9:0] col_add_in;
    logic       test_end;
    logic       early_term, done, repair, sol_valid, sol_ready, sol_is_col;
    logic [1:0] sol_bank;
    logic [9:0] sol_addr;

    typedef struct packed {
        logic       is_col;
        logic [1:0] bank;
        logic [9:0] addr;
    } sol_t;

    sol_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    bira_greedy_alloc #(.ROW_W(10), .COL_W(10), .BANK_W(2), .NUM_SR(2), .NUM_SC(2), .FCAM_D(16)) dut (
        .clk(clk), .rst(rst), .fault_detect(fault_detect), .bank_in(bank_in),
        .row_add_in(row_add_in), .col_add_in(col_add_in), .test_end(test_end),
        .early_term(early_term), .done(done), .repair(repair), .sol_valid(sol_valid),
        .sol_ready(sol_ready), .sol_is_col(sol_is_col), .sol_bank(sol_bank), .sol_addr(sol_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted solution entry is matched against the scoreboard
    sol_t mon_exp;
    always @(negedge clk) begin
        if (!rst && sol_valid && sol_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sol_unexpected actual=%0h expected=none", {sol_is_col, sol_bank, sol_addr});
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sol_entry", {19'd0, sol_is_col, sol_bank, sol_addr}, {19'd0, mon_exp});
            end
        end
    end

    task automatic expect_sol(input logic c, input logic [1:0] b, input logic [9:0] a);
        sb_q.push_back({c, b, a});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fault_detect = 1'b0; test_end = 1'b0; sol_ready = 1'b1;
        bank_in = '0; row_add_in = '0; col_add_in = '0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fault(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c);
        fault_detect = 1'b1; bank_in = b; row_add_in = r; col_add_in = c;
        @(posedge clk);
        #1 fault_detect = 1'b0;
    endtask

    task automatic end_test();
        test_end = 1'b1;
        @(posedge clk);
        #1 test_end = 1'b0;
    endtask

    task automatic finish_check(input string name, input logic exp_rep, input logic exp_et);
        int n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 600), 32'd1);
        @(negedge clk);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_repair"}, 32'(repair), 32'(exp_rep));
        chk({name, "_early_term"}, 32'(early_term), 32'(exp_et));
        chk({name, "_sol_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_outputs", {28'd0, early_term, done, repair, sol_valid}, 32'd0);

        // no faults
        end_test();
        finish_check("empty", 1'b1, 1'b0);

        // single row covers three faults
        do_reset();
        fault(2'd0, 10'd5, 10'd1); fault(2'd0, 10'd5, 10'd2); fault(2'd0, 10'd5, 10'd3);
        expect_sol(1'b0, 2'd0, 10'd5);
        end_test();
        finish_check("one_row", 1'b1, 1'b0);

        // tie resolves to row, second allocation picks the remaining row
        do_reset();
        fault(2'd0, 10'd2, 10'd7); fault(2'd0, 10'd2, 10'd9); fault(2'd0, 10'd6, 10'd7);
        expect_sol(1'b0, 2'd0, 10'd2); expect_sol(1'b0, 2'd0, 10'd6);
        end_test();
        finish_check("two_rows", 1'b1, 1'b0);

        // column beats row; fault coincident with test_end is captured
        do_reset();
        fault(2'd3, 10'd1, 10'd8); fault(2'd3, 10'd2, 10'd8);
        fault_detect = 1'b1; bank_in = 2'd3; row_add_in = 10'd3; col_add_in = 10'd8; test_end = 1'b1;
        @(posedge clk);
        #1 fault_detect = 1'b0; test_end = 1'b0;
        expect_sol(1'b1, 2'd3, 10'd8);
        finish_check("col_pick", 1'b1, 1'b0);

        // pool exhausted with a fault left uncovered
        do_reset();
        fault(2'd1, 10'd0, 10'd0); fault(2'd1, 10'd0, 10'd1); fault(2'd1, 10'd1, 10'd0);
        fault(2'd1, 10'd2, 10'd2); fault(2'd1, 10'd3, 10'd3); fault(2'd1, 10'd4, 10'd4);
        expect_sol(1'b0, 2'd1, 10'd0); expect_sol(1'b0, 2'd1, 10'd1);
        expect_sol(1'b1, 2'd1, 10'd2); expect_sol(1'b1, 2'd1, 10'd3);
        end_test();
        finish_check("exhaust", 1'b0, 1'b0);

        // five independent pivots exceed the pool
        do_reset();
        for (int i = 1; i <= 4; i++) fault(2'd1, 10'(i), 10'(i));
        chk("pivot4_et", 32'(early_term), 32'd0);
        fault(2'd1, 10'd5, 10'd5);
        chk("pivot5_et", 32'(early_term), 32'd1);
        chk("pivot5_done", 32'(done), 32'd1);
        fault(2'd2, 10'd9, 10'd9);
        end_test();
        finish_check("pivot", 1'b0, 1'b1);

        // duplicate stored once; 17th distinct fault overflows the CAM
        do_reset();
        fault(2'd0, 10'd0, 10'd0);
        fault(2'd0, 10'd0, 10'd0);
        for (int i = 1; i <= 15; i++) fault(2'd0, 10'd0, 10'(i));
        @(negedge clk);
        chk("cam16_et", 32'(early_term), 32'd0);
        chk("cam16_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        fault(2'd0, 10'd0, 10'd16);
        chk("cam17_et", 32'(early_term), 32'd1);
        finish_check("cam_full", 1'b0, 1'b1);

        // back-pressure: first entry held stable while ready is low
        do_reset();
        sol_ready = 1'b0;
        fault(2'd0, 10'd2, 10'd7); fault(2'd0, 10'd2, 10'd9); fault(2'd0, 10'd6, 10'd7);
        expect_sol(1'b0, 2'd0, 10'd2); expect_sol(1'b0, 2'd0, 10'd6);
        end_test();
        begin
            int n = 0;
            while (!sol_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("stall_valid_timeout", 32'(n < 300), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(sol_valid), 32'd1);
            chk("stall_entry", {19'd0, sol_is_col, sol_bank, sol_addr}, {19'd0, 1'b0, 2'd0, 10'd2});
        end
        @(posedge clk); #1 sol_ready = 1'b1;
        finish_check("stall", 1'b1, 1'b0);

        // reset during COUNT aborts, then a fresh collection works
        do_reset();
        fault(2'd0, 10'd5, 10'd1); fault(2'd0, 10'd5, 10'd2);
        end_test();
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_outputs", {28'd0, early_term, done, repair, sol_valid}, 32'd0);
        @(negedge clk);
        chk("abort_outputs_edge", {28'd0, early_term, done, repair, sol_valid}, 32'd0);
        do_reset();
        fault(2'd2, 10'd9, 10'd4); fault(2'd2, 10'd9, 10'd6);
        expect_sol(1'b0, 2'd2, 10'd9);
        end_test();
        finish_check("after_abort", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bira_greedy_alloc.md
Name: bira_greedy_alloc

Overview:
Parameterised built-in redundancy analyser for the BIST/BIRA chain. It records faulty cells reported by BIST into a fault CAM and tracks pivot faults so it can raise early termination. At test end it runs a deterministic greedy spare allocation over the stored faults. Allocated spare rows and columns are streamed out through a valid/ready handshake.

Parameters:
ROW_W, 10, row address width
COL_W, 10, column address width
BANK_W, 2, bank address width
NUM_SR, 2, spare rows in the shared pool (>=1)
NUM_SC, 2, spare columns in the shared pool (>=1)
FCAM_D, 16, fault CAM entries (>= NUM_SR+NUM_SC)

Ports:
clk  in  1  system clock
rst  in  1  reset
fault_detect  in  1  fault strobe from BIST, one fault per cycle
bank_in  in  BANK_W  faulty bank
row_add_in  in  ROW_W  faulty row
col_add_in  in  COL_W  faulty column
test_end  in  1  BIST finished (level or pulse)
early_term  out  1  unrepairable during collection; BIST stops
done  out  1  analysis complete
repair  out  1  valid when done: 1 = all stored faults covered
sol_valid  out  1  solution entry available
sol_ready  in  1  consumer accepts entry
sol_is_col  out  1  0 = spare row, 1 = spare column
sol_bank  out  BANK_W  bank of the repaired line
sol_addr  out  max(ROW_W,COL_W)  row or column address, zero-extended

Behaviour:
- One clock, clk. Reset rst is asynchronous, active-high. On reset, all outputs are 0, the CAM is cleared, counters are 0, and state is COLLECT.
- States: COLLECT -> FIND -> COUNT -> MARK -> (FIND | EMIT) -> DONE.
- COLLECT: each cycle with fault_detect=1, compare {bank,row,col} against valid entries.
  - Exact duplicate: ignored.
  - Otherwise: written to the next free entry.
  - Pivot rule: the fault is a pivot if no stored pivot has the same bank and (same row or same col). Pivot entries are flagged.
- Early termination: the pivot count reaching NUM_SR+NUM_SC+1, or a new non-duplicate fault arriving with the CAM full, sets early_term one cycle after the offending fault.
  - early_term stays high until reset.
  - The block goes directly to DONE with repair=0 and emits nothing.
- test_end=1 in COLLECT moves to FIND next cycle. A fault_detect in the same cycle as test_end is captured. fault_detect outside COLLECT is ignored.
- FIND: scan entries 0..FCAM_D-1, one per cycle, for the lowest-index valid uncovered entry P.
  - None found: repair=1, go to EMIT.
  - Found but no spares left: repair=0, go to EMIT.
- COUNT: one scan, one entry per cycle, counting uncovered entries with P's bank and row (rc) and with P's bank and col (cc).
  - Counter width covers FCAM_D.
  - Choose row if (rc>=cc and rows_left>0) or cols_left==0; otherwise choose col.
  - Decrement the chosen pool and append {is_col, bank, addr} to the solution list (depth NUM_SR+NUM_SC).
- MARK: one scan setting covered on every entry on the chosen line in that bank, then return to FIND.
- EMIT: present the solution list in allocation order.
  - An entry transfers on sol_valid && sol_ready.
  - sol_* stay stable while sol_valid=1 && sol_ready=0.
  - After the last transfer, or immediately if the list is empty, go to DONE.
- done and repair are asserted together and only on entry to DONE. DONE holds until reset.
- Analysis bound: each allocation takes at most 3*FCAM_D cycles.
- A reset mid-scan or mid-emit aborts and clears everything. No partial outputs persist.

Test Plan:
- No faults, test_end pulse -> done=1, repair=1, sol_valid never asserted, early_term=0.
- Faults b0 (r5,c1),(r5,c2),(r5,c3), then test_end -> single solution is_col=0 bank=0 addr=5, repair=1.
- Faults b0 (r2,c7),(r2,c9),(r6,c7) -> solutions in order: row b0 2, row b0 6; repair=1.
- Five faults b1 (r1,c1)..(r5,c5) -> early_term=1 one cycle after the 5th fault, done=1, repair=0, no solutions; further faults have no effect.
- 17 distinct faults b0 row 0 cols 0..16 with FCAM_D=16 -> early_term on the 17th fault. The same fault sent twice is stored once (check CAM occupancy).
- Two-entry solution with sol_ready held low 5 cycles -> first entry held stable, both delivered in order once ready rises. Reset asserted during COUNT -> all outputs 0 next edge, new collection works.
